// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with a 2-entry skid buffer between fetch and execute.
// Decoding is done on the incoming word at acceptance, so the buffer stores decoded fields.
module decode_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ILEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_fmt,
    output logic            out_illegal
);

    localparam logic [2:0] FmtNone = 3'd0;
    localparam logic [2:0] FmtI    = 3'd1;
    localparam logic [2:0] FmtS    = 3'd2;
    localparam logic [2:0] FmtB    = 3'd3;
    localparam logic [2:0] FmtU    = 3'd4;
    localparam logic [2:0] FmtJ    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      imm_fmt;
        logic            illegal;
    } entry_t;

    // Occupancy of the skid buffer
    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e r_state, r_state_d;
    entry_t r_ent0, r_ent0_d;  // head, drives out_*
    entry_t r_ent1, r_ent1_d;  // second entry, only meaningful in StTwo
    logic   r_in_ready, r_in_ready_d;

    entry_t     w_dec;
    logic [2:0] w_fmt;
    logic       w_illegal;
    logic [31:0] w_imm32;
    logic       w_in_xfer;
    logic       w_out_xfer;

    // Opcode classification: immediate format and legality
    always_comb begin
        w_fmt     = FmtNone;
        w_illegal = 1'b0;
        // Opcode includes bits [1:0], so any non-11 low bits fall into default
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111,
            7'b0001111, 7'b1110011:              w_fmt = FmtI;
            7'b0011011: begin
                if (XLEN == 64) w_fmt = FmtI;
                else            w_illegal = 1'b1;
            end
            7'b0100011:                          w_fmt = FmtS;
            7'b1100011:                          w_fmt = FmtB;
            7'b0110111, 7'b0010111:              w_fmt = FmtU;
            7'b1101111:                          w_fmt = FmtJ;
            7'b0110011:                          w_fmt = FmtNone;
            7'b0111011: begin
                if (XLEN != 64) w_illegal = 1'b1;
            end
            default:                             w_illegal = 1'b1;
        endcase
    end

    // Immediate assembly, first to 32 bits then sign-extended to XLEN
    always_comb begin
        w_imm32 = 32'd0;
        case (w_fmt)
            FmtI: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FmtS: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FmtB: w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
            FmtU: w_imm32 = {in_instr[31:12], 12'd0};
            FmtJ: w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    // Pack the decoded entry for capture
    always_comb begin
        w_dec         = '0;
        w_dec.pc      = in_pc;
        w_dec.opcode  = in_instr[6:0];
        w_dec.rd      = in_instr[11:7];
        w_dec.funct3  = in_instr[14:12];
        w_dec.rs1     = in_instr[19:15];
        w_dec.rs2     = in_instr[24:20];
        w_dec.funct7  = in_instr[31:25];
        w_dec.imm     = XLEN'($signed(w_imm32));
        w_dec.imm_fmt = w_fmt;
        w_dec.illegal = w_illegal;
    end

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Skid FSM next state, entry movement and registered ready
    always_comb begin
        r_state_d = r_state;
        r_ent0_d  = r_ent0;
        r_ent1_d  = r_ent1;
        case (r_state)
            StEmpty: begin
                if (w_in_xfer) begin
                    r_ent0_d  = w_dec;
                    r_state_d = StOne;
                end
            end
            StOne: begin
                if (w_in_xfer && w_out_xfer) begin
                    r_ent0_d = w_dec;
                end else if (w_in_xfer) begin
                    r_ent1_d  = w_dec;
                    r_state_d = StTwo;
                end else if (w_out_xfer) begin
                    r_state_d = StEmpty;
                end
            end
            StTwo: begin
                if (w_out_xfer) begin
                    r_ent0_d  = r_ent1;
                    r_state_d = StOne;
                end
            end
            default: r_state_d = StEmpty;
        endcase
        // Flush drops any same-cycle input; an output transfer already happened downstream
        if (flush) r_state_d = StEmpty;
        r_in_ready_d = (r_state_d != StTwo);
    end

    // State and storage registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StEmpty;
            r_ent0     <= '0;
            r_ent1     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= r_state_d;
            r_ent0     <= r_ent0_d;
            r_ent1     <= r_ent1_d;
            r_in_ready <= r_in_ready_d;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != StEmpty);
    assign out_pc      = r_ent0.pc;
    assign out_opcode  = r_ent0.opcode;
    assign out_rd      = r_ent0.rd;
    assign out_rs1     = r_ent0.rs1;
    assign out_rs2     = r_ent0.rs2;
    assign out_funct3  = r_ent0.funct3;
    assign out_funct7  = r_ent0.funct7;
    assign out_imm     = r_ent0.imm;
    assign out_imm_fmt = r_ent0.imm_fmt;
    assign out_illegal = r_ent0.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one XLEN=32 and one XLEN=64 instance share the stimulus.
module tb_decode_stage;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        r32_ready, o32_valid, o32_illegal;
    logic [31:0] o32_pc, o32_imm;
    logic [6:0]  o32_opcode, o32_funct7;
    logic [4:0]  o32_rd, o32_rs1, o32_rs2;
    logic [2:0]  o32_funct3, o32_fmt;

    logic        r64_ready, o64_valid, o64_illegal;
    logic [63:0] o64_pc, o64_imm;
    logic [6:0]  o64_opcode, o64_funct7;
    logic [4:0]  o64_rd, o64_rs1, o64_rs2;
    logic [2:0]  o64_funct3, o64_fmt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int n_snap;

    decode_stage #(.XLEN(32), .ILEN(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r32_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(o32_valid), .out_ready(out_ready), .out_pc(o32_pc),
        .out_opcode(o32_opcode), .out_rd(o32_rd), .out_rs1(o32_rs1), .out_rs2(o32_rs2),
        .out_funct3(o32_funct3), .out_funct7(o32_funct7), .out_imm(o32_imm),
        .out_imm_fmt(o32_fmt), .out_illegal(o32_illegal)
    );

    decode_stage #(.XLEN(64), .ILEN(32)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r64_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(o64_valid), .out_ready(out_ready), .out_pc(o64_pc),
        .out_opcode(o64_opcode), .out_rd(o64_rd), .out_rs1(o64_rs1), .out_rs2(o64_rs2),
        .out_funct3(o64_funct3), .out_funct7(o64_funct7), .out_imm(o64_imm),
        .out_imm_fmt(o64_fmt), .out_illegal(o64_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed output transfers on the 32-bit instance
    always @(posedge clk) begin
        if (reset_n && o32_valid && out_ready) n_out <= n_out + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction to an empty stage with out_ready=1; afterwards the entry is on out_*
    task automatic dec1(input logic [31:0] instr, input logic [63:0] pc);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 64'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", o32_valid, 0);
        check_eq("rst_ready", r32_ready, 1);
        check_eq("rst_imm", o32_imm, 0);
        check_eq("rst_pc", o32_pc, 0);
        check_eq("rst_rd", o32_rd, 0);
        check_eq("rst_fmt", o32_fmt, 0);
        reset_n = 1'b1;
        tick();

        // addi x1,x0,-1
        dec1(32'hFFF00093, 64'h100);
        check_eq("addi_valid", o32_valid, 1);
        check_eq("addi_rd", o32_rd, 1);
        check_eq("addi_rs1", o32_rs1, 0);
        check_eq("addi_fmt", o32_fmt, 1);
        check_eq("addi_imm", o32_imm, 64'hFFFFFFFF);
        check_eq("addi_pc", o32_pc, 64'h100);
        check_eq("addi_ill", o32_illegal, 0);
        check_eq("addi_imm64", o64_imm, 64'hFFFFFFFFFFFFFFFF);
        tick();
        check_eq("addi_drain", o32_valid, 0);

        dec1(32'h008000EF, 64'h104);
        check_eq("jal_fmt", o32_fmt, 5);
        check_eq("jal_imm", o32_imm, 8);
        check_eq("jal_rd", o32_rd, 1);
        tick();

        dec1(32'hFE000EE3, 64'h108);
        check_eq("beq_fmt", o32_fmt, 3);
        check_eq("beq_imm", o32_imm, 64'hFFFFFFFC);
        check_eq("beq_imm64", o64_imm, 64'hFFFFFFFFFFFFFFFC);
        check_eq("beq_f3", o32_funct3, 0);
        tick();

        dec1(32'hFE20AC23, 64'h10C);
        check_eq("sw_fmt", o32_fmt, 2);
        check_eq("sw_imm", o32_imm, 64'hFFFFFFF8);
        check_eq("sw_rs1", o32_rs1, 1);
        check_eq("sw_rs2", o32_rs2, 2);
        check_eq("sw_f3", o32_funct3, 2);
        check_eq("sw_f7", o32_funct7, 7'h7F);
        tick();

        dec1(32'h123450B7, 64'h110);
        check_eq("lui_fmt", o32_fmt, 4);
        check_eq("lui_imm", o32_imm, 64'h12345000);
        check_eq("lui_op", o32_opcode, 7'h37);
        tick();

        // U immediate with bit 31 set sign-extends on the 64-bit instance
        dec1(32'h800000B7, 64'h114);
        check_eq("luineg_imm64", o64_imm, 64'hFFFFFFFF80000000);
        tick();

        dec1(32'h00000000, 64'h118);
        check_eq("zero_ill", o32_illegal, 1);
        check_eq("zero_fmt", o32_fmt, 0);
        check_eq("zero_imm", o32_imm, 0);
        tick();

        dec1(32'hFFFFFFFF, 64'h11C);
        check_eq("ones_ill", o32_illegal, 1);
        check_eq("ones_imm", o32_imm, 0);
        tick();

        dec1(32'h0000005B, 64'h120);
        check_eq("op5b_ill", o32_illegal, 1);
        tick();

        dec1(32'h0000001B, 64'h124);
        check_eq("op1b_ill32", o32_illegal, 1);
        check_eq("op1b_ill64", o64_illegal, 0);
        check_eq("op1b_fmt64", o64_fmt, 1);
        tick();

        dec1(32'h0000003B, 64'h128);
        check_eq("op3b_ill32", o32_illegal, 1);
        check_eq("op3b_ill64", o64_illegal, 0);
        tick();

        dec1(32'h002081B3, 64'h12C);  // add x3,x1,x2
        check_eq("add_fmt", o32_fmt, 0);
        check_eq("add_ill", o32_illegal, 0);
        check_eq("add_rd", o32_rd, 3);
        tick();

        // Backpressure: stream A, B, C with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_pc     = 64'h200;
        tick();
        check_eq("bp_one_ready", r32_ready, 1);
        in_instr = 32'h123450B7;
        in_pc    = 64'h204;
        tick();
        check_eq("bp_two_ready", r32_ready, 0);
        in_instr = 32'h008000EF;
        in_pc    = 64'h208;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_stall_valid", o32_valid, 1);
            check_eq("bp_stall_pc", o32_pc, 64'h200);
            check_eq("bp_stall_imm", o32_imm, 64'hFFFFFFFF);
            check_eq("bp_stall_ready", r32_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        check_eq("bp_b_pc", o32_pc, 64'h204);
        check_eq("bp_b_imm", o32_imm, 64'h12345000);
        check_eq("bp_b_ready", r32_ready, 1);
        tick();
        in_valid = 1'b0;
        check_eq("bp_c_pc", o32_pc, 64'h208);
        check_eq("bp_c_imm", o32_imm, 8);
        tick();
        check_eq("bp_empty", o32_valid, 0);

        // Flush at occupancy TWO with an incoming instruction and a head transfer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_pc     = 64'h300;
        tick();
        in_pc = 64'h304;
        tick();
        in_pc     = 64'h308;
        flush     = 1'b1;
        out_ready = 1'b1;
        n_snap    = n_out;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("fl_valid", o32_valid, 0);
        check_eq("fl_ready", r32_ready, 1);
        check_eq("fl_headxfer", n_out, n_snap + 1);
        tick();
        check_eq("fl_dropped", o32_valid, 0);

        // Asynchronous reset at occupancy ONE
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h008000EF;
        in_pc     = 64'h400;
        tick();
        in_valid = 1'b0;
        check_eq("ar_one", o32_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("ar_valid", o32_valid, 0);
        check_eq("ar_ready", r32_ready, 1);
        check_eq("ar_pc", o32_pc, 0);
        #1;
        reset_n = 1'b1;
        tick();
        dec1(32'hFE20AC23, 64'h500);
        check_eq("ar_after_valid", o32_valid, 1);
        check_eq("ar_after_imm", o32_imm, 64'hFFFFFFF8);
        check_eq("ar_after_pc", o32_pc, 64'h500);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I/RV64I instruction decode stage between fetch and execute.
- Accepts raw instruction words with PC over a valid/ready handshake.
- Extracts register indices and funct fields. Selects and sign-extends the correct immediate (I/S/B/U/J) per opcode, and flags illegal encodings.
- Contains a 2-entry skid buffer so downstream backpressure never creates a combinational ready path to fetch.

Parameters:
- XLEN, 32, datapath width; 32 or 64 only. 64 also enables OP-IMM-32 (0011011) and OP-32 (0111011) as legal.
- ILEN, 32, instruction width; fixed at 32.

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  discard all buffered entries (branch redirect)
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept; registered
- in_instr  input  ILEN  raw instruction bits
- in_pc  input  XLEN  PC of in_instr
- out_valid  output  1  decoded entry available
- out_ready  input  1  execute accepts entry
- out_pc  output  XLEN  PC of decoded entry
- out_opcode  output  7  instr[6:0]
- out_rd  output  5  instr[11:7]
- out_rs1  output  5  instr[19:15]
- out_rs2  output  5  instr[24:20]
- out_funct3  output  3  instr[14:12]
- out_funct7  output  7  instr[31:25]
- out_imm  output  XLEN  selected immediate, sign-extended to XLEN
- out_imm_fmt  output  3  0=none, 1=I, 2=S, 3=B, 4=U, 5=J
- out_illegal  output  1  encoding not recognised

Behaviour:
- Reset (reset_n low, async):
  - occupancy 0, out_valid=0, in_ready=1.
  - All data outputs are 0.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: an accepted instruction appears on out_* on the next rising edge when the stage was empty.
- Decode is combinational on in_instr and is captured at acceptance. Stored entries hold decoded fields, not raw bits.
- Immediates:
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25], instr[11:7]}).
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}), 13 bits.
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}), 21 bits.
  - U = sext({instr[31:12], 12'b0}) to XLEN.
- Format select by opcode:
  - I: LOAD 0000011, OP-IMM 0010011, JALR 1100111, MISC-MEM 0001111, SYSTEM 1110011, OP-IMM-32 (XLEN=64).
  - S: STORE 0100011.
  - B: BRANCH 1100011.
  - U: LUI 0110111, AUIPC 0010111.
  - J: JAL 1101111.
  - none (imm=0): OP 0110011, OP-32 (XLEN=64).
- Illegal:
  - out_illegal=1 when instr[1:0]!=2'b11 or the opcode is not in the list above (includes 0x00000000 and 0xFFFFFFFF).
  - An illegal entry still flows through with imm_fmt=0 and imm=0.
- Skid FSM, state = occupancy:
  - EMPTY→ONE on input transfer.
  - ONE→EMPTY on output transfer without input transfer.
  - ONE→TWO on input transfer without output transfer.
  - ONE stays ONE on simultaneous input and output transfers.
  - TWO→ONE on output transfer. No input transfer is possible in TWO.
- FIFO order is strict. Head entry drives out_*. In TWO, the second entry moves to head on an output transfer.
- in_ready is registered: in_ready = (next occupancy != TWO). It deasserts the cycle after the buffer fills.
- out_* must be held stable while out_valid && !out_ready.
- flush (synchronous):
  - Next state EMPTY, out_valid=0, in_ready=1.
  - An input transfer in the same cycle is dropped.
  - An output transfer in the same cycle still completes, since downstream has already sampled it.
- Mid-operation reset: asserting reset_n low at any occupancy immediately clears out_valid and sets in_ready=1.

Test Plan:
- Empty stage, single accept 0xFFF00093 (addi x1,x0,-1), pc=0x100, out_ready=1:
  - next cycle out_valid=1, rd=1, rs1=0, fmt=1, imm=0xFFFFFFFF, pc=0x100, illegal=0.
- Immediate formats:
  - 0x008000EF (jal x1,8) → fmt=5, imm=8.
  - 0xFE000EE3 (beq x0,x0,-4) → fmt=3, imm=0xFFFFFFFC.
  - 0xFE20AC23 (sw x2,-8(x1)) → fmt=2, imm=0xFFFFFFF8, rs1=1, rs2=2.
  - 0x123450B7 (lui) → fmt=4, imm=0x12345000.
  - With XLEN=64, the beq case gives imm=0xFFFFFFFFFFFFFFFC.
- Illegal encodings:
  - 0x00000000 → illegal=1, fmt=0, imm=0.
  - 0x0000005B (unused opcode) → illegal=1.
  - 0x0000001B → illegal only when XLEN=32.
- Backpressure:
  - Hold out_ready=0 and stream 3 instructions.
  - Occupancy reaches TWO and in_ready drops the following cycle; the third instruction is held by fetch.
  - Raise out_ready: entries emerge in order with no loss or duplication and out_* stable while stalled.
- Flush:
  - Occupancy TWO, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, the incoming instruction is dropped.
  - Same-cycle output transfer of the head is still counted.
- Reset mid-stream:
  - Drop reset_n asynchronously at occupancy ONE → out_valid=0 without waiting for a clock edge.
  - After release, the first accepted instruction decodes normally.
